// File: rtl/rv_pkg.sv
// Shared write-back types and widths for the register-file writer side.
package rv_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NREGS    = 2 ** REG_AW;
    localparam int WB_DEPTH = 4;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_LD   = 2'd2
    } wb_src_e;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; head is read combinationally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign full      = (count_r == DEPTH[PW:0]);
    assign empty     = (count_r == {(PW+1){1'b0}});
    assign count     = count_r;
    assign rdata     = mem_r[rd_ptr_r];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back sequencer: arbitrates ALU results against buffered load returns
// onto the regfile write port and tracks registers with outstanding loads.
module regfile_wb_ctrl #(
    parameter int XLEN  = rv_pkg::XLEN,
    parameter int AW    = rv_pkg::REG_AW,
    parameter int DEPTH = rv_pkg::WB_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    input  logic [AW-1:0]          alu_rd,
    input  logic [XLEN-1:0]        alu_data,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [AW-1:0]          ld_rd,
    input  logic [XLEN-1:0]        ld_data,
    input  logic                   issue_ld,
    input  logic [AW-1:0]          issue_rd,
    input  logic [AW-1:0]          dec_rs1,
    input  logic [AW-1:0]          dec_rs2,
    input  logic [AW-1:0]          dec_rd,
    output logic                   hazard,
    output logic                   rf_we_n,
    output logic [AW-1:0]          rf_rd,
    output logic [XLEN-1:0]        rf_wd,
    output logic [2**AW-1:0]       pend,
    output logic [$clog2(DEPTH):0] fifo_cnt
);
    import rv_pkg::*;

    localparam int NR = 2 ** AW;
    localparam logic [NR-1:0] BIT0 = {{(NR-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] X0   = {AW{1'b0}};

    logic                 alu_sel_s;
    logic                 pop_s;
    logic                 push_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [AW+XLEN-1:0]   head_s;
    logic                 rf_we_n_r;
    logic [AW-1:0]        rf_rd_r;
    logic [XLEN-1:0]      rf_wd_r;
    wb_src_e              src_r;
    logic [NR-1:0]        pend_r;
    logic [NR-1:0]        set_s;
    logic [NR-1:0]        clr_s;
    logic [NR-1:0]        pend_nxt_s;

    // An ALU write to x0 is discarded, so it never blocks a FIFO pop.
    assign alu_sel_s = alu_valid && (alu_rd != X0);
    assign pop_s     = !alu_sel_s && !fifo_empty_s;
    assign push_s    = ld_valid && !fifo_full_s && (ld_rd != X0);
    assign ld_ready  = !fifo_full_s;

    sync_fifo #(
        .WIDTH (AW + XLEN),
        .DEPTH (DEPTH)
    ) u_ld_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata ({ld_rd, ld_data}),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_cnt)
    );

    // Output stage: one write per cycle, index/data hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_n_r <= 1'b1;
            rf_rd_r   <= X0;
            rf_wd_r   <= {XLEN{1'b0}};
            src_r     <= WB_NONE;
        end else if (alu_sel_s) begin
            rf_we_n_r <= 1'b0;
            rf_rd_r   <= alu_rd;
            rf_wd_r   <= alu_data;
            src_r     <= WB_ALU;
        end else if (pop_s) begin
            rf_we_n_r <= 1'b0;
            rf_rd_r   <= head_s[AW+XLEN-1:XLEN];
            rf_wd_r   <= head_s[XLEN-1:0];
            src_r     <= WB_LD;
        end else begin
            rf_we_n_r <= 1'b1;
            src_r     <= WB_NONE;
        end
    end

    // A pending bit clears as the regfile captures its load; a same-edge issue wins.
    assign clr_s      = (!rf_we_n_r && (src_r == WB_LD)) ? (BIT0 << rf_rd_r) : {NR{1'b0}};
    assign set_s      = (issue_ld && (issue_rd != X0)) ? (BIT0 << issue_rd) : {NR{1'b0}};
    assign pend_nxt_s = ((pend_r & ~clr_s) | set_s) & ~BIT0;

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_r <= {NR{1'b0}};
        end else begin
            pend_r <= pend_nxt_s;
        end
    end

    assign hazard = ((dec_rs1 != X0) && pend_r[dec_rs1]) ||
                    ((dec_rs2 != X0) && pend_r[dec_rs2]) ||
                    ((dec_rd  != X0) && pend_r[dec_rd]);

    assign rf_we_n = rf_we_n_r;
    assign rf_rd   = rf_rd_r;
    assign rf_wd   = rf_wd_r;
    assign pend    = pend_r;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: vector table plus multi-cycle sequences.
module tb_regfile_wb_ctrl;
    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        issue_ld;
    logic [4:0]  issue_rd;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        hazard;
    logic        rf_we_n;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;
    logic [31:0] pend;
    logic [2:0]  fifo_cnt;

    int errors = 0;
    int checks = 0;
    int wr_count = 0;
    bit mon_en = 1'b0;
    int next_exp = 1;
    logic [31:0] rf_model [32];

    regfile_wb_ctrl #(.XLEN(32), .AW(5), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .issue_ld(issue_ld), .issue_rd(issue_rd),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .hazard(hazard), .rf_we_n(rf_we_n), .rf_rd(rf_rd), .rf_wd(rf_wd),
        .pend(pend), .fifo_cnt(fifo_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Regfile model and write counter.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) rf_model[r] <= 32'h0;
        end else if (!rf_we_n) begin
            rf_model[rf_rd] <= rf_wd;
            wr_count <= wr_count + 1;
        end
    end

    // Invariants and in-order load write monitor.
    always @(negedge clk) begin
        if (fifo_cnt > 3'd4) begin
            errors++;
            $display("FAIL fifo_overflow: got %0d expected <=4", fifo_cnt);
        end
        if (!rf_we_n && rf_rd == 5'd0) begin
            errors++;
            $display("FAIL x0_write: got we_n=0 rd=0 expected no write");
        end
        if (mon_en && !rf_we_n && rf_rd != 5'd31) begin
            chk("wrap_rd", {27'd0, rf_rd}, next_exp);
            chk("wrap_wd", rf_wd, 32'h100 + next_exp);
            next_exp = next_exp + 1;
        end
    end

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic        e_rdy;
        logic        e_hz;
        logic        e_wen;
        logic [4:0]  e_rd;
        logic [31:0] e_wd;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                                input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                                input logic e_rdy, input logic e_wen, input logic [4:0] e_rd,
                                input logic [31:0] e_wd, input logic [2:0] e_cnt);
        vec_t v;
        v.av = av; v.ard = ard; v.adat = adat;
        v.lv = lv; v.lrd = lrd; v.ldat = ldat;
        v.e_rdy = e_rdy; v.e_hz = 1'b0; v.e_wen = e_wen;
        v.e_rd = e_rd; v.e_wd = e_wd; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'h0;
        ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'h0;
        issue_ld = 1'b0; issue_rd = 5'd0;
        dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rd = 5'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_run(input bit reissue);
        idle_inputs();
        issue_ld = 1'b1; issue_rd = 5'd9; dec_rs2 = 5'd9;
        #1 chk("sb_hz_before_set", {31'd0, hazard}, 32'd0);
        tick();
        issue_ld = 1'b0;
        chk("sb_pend_set", pend, 32'h200);
        if (!reissue) begin
            dec_rs2 = 5'd0; dec_rd = 5'd9;
            #1 chk("sb_hz_rd_term", {31'd0, hazard}, 32'd1);
            dec_rd = 5'd0; dec_rs1 = 5'd9;
            #1 chk("sb_hz_rs1_term", {31'd0, hazard}, 32'd1);
            dec_rs1 = 5'd0;
            #1 chk("sb_hz_none", {31'd0, hazard}, 32'd0);
            dec_rs2 = 5'd9;
        end
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99;
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66;
        #1 chk("sb_hz_pending", {31'd0, hazard}, 32'd1);
        tick();
        ld_valid = 1'b0; alu_valid = 1'b0;
        chk("sb_cnt_pushed", {29'd0, fifo_cnt}, 32'd1);
        #1 chk("sb_hz_popping", {31'd0, hazard}, 32'd1);
        tick();
        chk("sb_ld_we", {31'd0, rf_we_n}, 32'd0);
        chk("sb_ld_rd", {27'd0, rf_rd}, 32'd9);
        chk("sb_ld_wd", rf_wd, 32'h99);
        chk("sb_pend_held", pend, 32'h200);
        issue_ld = reissue; issue_rd = 5'd9;
        #1 chk("sb_hz_capture", {31'd0, hazard}, 32'd1);
        tick();
        issue_ld = 1'b0;
        chk("sb_pend_after_clear", pend, reissue ? 32'h200 : 32'h0);
        #1 chk("sb_hz_after_clear", {31'd0, hazard}, {31'd0, reissue});
        if (reissue) begin
            ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h77;
            tick();
            ld_valid = 1'b0;
            tick();
            tick();
            chk("sb_pend_final", pend, 32'h0);
        end else begin
            issue_ld = 1'b1; issue_rd = 5'd0;
            tick();
            issue_ld = 1'b0;
            chk("sb_pend_x0", pend, 32'h0);
        end
        idle_inputs();
    endtask

    initial begin
        int sent;
        int cyc;
        int wc;
        bit acc;

        tbl[0]  = mk(1'b1, 5'd5,  32'h1234, 1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 5'd5,  32'h1234, 3'd0);
        tbl[1]  = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,  1'b1, 1'b1, 5'd5,  32'h1234, 3'd0);
        tbl[2]  = mk(1'b0, 5'd0,  32'h0,    1'b1, 5'd7,  32'hAA, 1'b1, 1'b1, 5'd5,  32'h1234, 3'd1);
        tbl[3]  = mk(1'b1, 5'd0,  32'h55,   1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 5'd7,  32'hAA,   3'd0);
        tbl[4]  = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,  1'b1, 1'b1, 5'd7,  32'hAA,   3'd0);
        tbl[5]  = mk(1'b1, 5'd20, 32'hC0,   1'b1, 5'd11, 32'hB1, 1'b1, 1'b0, 5'd20, 32'hC0,   3'd1);
        tbl[6]  = mk(1'b1, 5'd21, 32'hC1,   1'b1, 5'd12, 32'hB2, 1'b1, 1'b0, 5'd21, 32'hC1,   3'd2);
        tbl[7]  = mk(1'b1, 5'd22, 32'hC2,   1'b1, 5'd13, 32'hB3, 1'b1, 1'b0, 5'd22, 32'hC2,   3'd3);
        tbl[8]  = mk(1'b1, 5'd23, 32'hC3,   1'b1, 5'd14, 32'hB4, 1'b1, 1'b0, 5'd23, 32'hC3,   3'd4);
        tbl[9]  = mk(1'b1, 5'd24, 32'hC4,   1'b1, 5'd15, 32'hB5, 1'b0, 1'b0, 5'd24, 32'hC4,   3'd4);
        tbl[10] = mk(1'b1, 5'd25, 32'hC5,   1'b0, 5'd0,  32'h0,  1'b0, 1'b0, 5'd25, 32'hC5,   3'd4);
        tbl[11] = mk(1'b0, 5'd0,  32'h0,    1'b1, 5'd16, 32'hE0, 1'b0, 1'b0, 5'd11, 32'hB1,   3'd3);
        tbl[12] = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 5'd12, 32'hB2,   3'd2);
        tbl[13] = mk(1'b0, 5'd0,  32'h0,    1'b1, 5'd0,  32'hDD, 1'b1, 1'b0, 5'd13, 32'hB3,   3'd1);
        tbl[14] = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 5'd14, 32'hB4,   3'd0);
        tbl[15] = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,  1'b1, 1'b1, 5'd14, 32'hB4,   3'd0);

        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we_n", {31'd0, rf_we_n}, 32'd1);
        chk("rst_rd", {27'd0, rf_rd}, 32'd0);
        chk("rst_wd", rf_wd, 32'h0);
        chk("rst_cnt", {29'd0, fifo_cnt}, 32'd0);
        chk("rst_pend", pend, 32'h0);
        chk("rst_ready", {31'd0, ld_ready}, 32'd1);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].adat;
            ld_valid = tbl[i].lv; ld_rd = tbl[i].lrd; ld_data = tbl[i].ldat;
            #1;
            chk($sformatf("v%0d_ready", i), {31'd0, ld_ready}, {31'd0, tbl[i].e_rdy});
            chk($sformatf("v%0d_hazard", i), {31'd0, hazard}, {31'd0, tbl[i].e_hz});
            tick();
            chk($sformatf("v%0d_we_n", i), {31'd0, rf_we_n}, {31'd0, tbl[i].e_wen});
            chk($sformatf("v%0d_rd", i), {27'd0, rf_rd}, {27'd0, tbl[i].e_rd});
            chk($sformatf("v%0d_wd", i), rf_wd, tbl[i].e_wd);
            chk($sformatf("v%0d_cnt", i), {29'd0, fifo_cnt}, {29'd0, tbl[i].e_cnt});
        end
        idle_inputs();
        chk("rf_x5", rf_model[5], 32'h1234);
        chk("rf_x7", rf_model[7], 32'hAA);

        sb_run(1'b0);
        sb_run(1'b1);

        // Reset with three loads buffered and two registers pending.
        issue_ld = 1'b1; issue_rd = 5'd3;
        tick();
        issue_rd = 5'd4;
        tick();
        issue_ld = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h2020;
        for (int k = 0; k < 3; k++) begin
            ld_valid = 1'b1; ld_rd = 5'd3 + k[4:0]; ld_data = 32'h300 + k;
            tick();
        end
        ld_valid = 1'b0;
        chk("pre_rst_cnt", {29'd0, fifo_cnt}, 32'd3);
        chk("pre_rst_pend", pend, 32'h18);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_we_n", {31'd0, rf_we_n}, 32'd1);
        chk("mid_rst_cnt", {29'd0, fifo_cnt}, 32'd0);
        chk("mid_rst_pend", pend, 32'h0);
        chk("mid_rst_ready", {31'd0, ld_ready}, 32'd1);
        chk("mid_rst_rd", {27'd0, rf_rd}, 32'd0);
        wc = wr_count;
        tick();
        rst = 1'b0;
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("post_rst_we_n%0d", k), {31'd0, rf_we_n}, 32'd1);
        end
        chk("post_rst_no_write", wr_count, wc);

        // Wrap: ten loads through a four-entry FIFO, ALU busy every other cycle.
        mon_en = 1'b1;
        sent = 0;
        cyc = 0;
        while (sent < 10 && cyc < 200) begin
            ld_valid = 1'b1; ld_rd = 5'(sent + 1); ld_data = 32'h100 + sent + 1;
            alu_valid = (cyc % 2 == 0); alu_rd = 5'd31; alu_data = 32'hF00D;
            #1 acc = ld_ready;
            tick();
            if (acc) sent++;
            cyc++;
        end
        idle_inputs();
        chk("wrap_sent", sent, 10);
        cyc = 0;
        while (fifo_cnt != 3'd0 && cyc < 20) begin
            tick();
            cyc++;
        end
        tick();
        tick();
        mon_en = 1'b0;
        chk("wrap_all_written", next_exp, 11);
        chk("wrap_cnt_empty", {29'd0, fifo_cnt}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
